// File: rtl/ulpb_tx_sequencer_pkg.sv
// Shared types for the ULPB TX sequencer: buffer entry layout and FSM states.
// Bus widths normally come from include/ulpb_def.v; local defaults apply when it is absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ulpb_tx_sequencer_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  typedef struct packed {
    logic              prio;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic [DATA_W-1:0] data;
  } tx_entry_t;

  localparam int ENTRY_W = $bits(tx_entry_t);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_ACK_LOW  = 3'd3,
    S_RESP     = 3'd4,
    S_RESP_CLR = 3'd5,
    S_DISCARD  = 3'd6
  } tx_state_t;

endpackage

// File: rtl/ulpb_tx_buf.sv
// Message buffer: words from msg_start up to rd_ptr stay resident so an in-flight
// message can be replayed or skipped; only commit frees them.
module ulpb_tx_buf
  import ulpb_tx_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic               rd_adv,
  input  logic               rd_rewind,
  input  logic               commit,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        msg_start;
  logic [AW:0]        occupancy;
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      msg_start <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_rewind)
        rd_ptr <= msg_start;
      else if (rd_adv)
        rd_ptr <= rd_ptr + 1'b1;
      // A commit issued while stepping past the final word frees that word too.
      if (commit)
        msg_start <= rd_adv ? rd_ptr + 1'b1 : rd_ptr;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign rd_entry  = mem[rd_ptr[AW-1:0]];
  assign occupancy = wr_ptr - msg_start;
  assign full      = (occupancy == FULL_OCC);

endmodule

// File: rtl/ulpb_tx_sequencer.sv
// Feeds buffered messages into the ULPB node TX handshake and resolves SUCC/FAIL.
// Define ULPB_TX_RETRY_EN to replay failed messages up to MAX_RETRY times before dropping.
module ulpb_tx_sequencer
  import ulpb_tx_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
`ifdef ULPB_TX_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_LAST,
  input  logic              WR_PRIO,
  output logic              FULL,
  output logic              BUSY,
  output logic              MSG_DONE,
  output logic              MSG_ERR,
  output logic [ADDR_W-1:0] TX_ADDR,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_PEND,
  output logic              TX_REQ,
  output logic              TX_PRIORITY,
  input  logic              TX_ACK,
  input  logic              TX_SUCC,
  input  logic              TX_FAIL,
  output logic              TX_RESP_ACK
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t          state, state_nxt;
  logic [CW-1:0]      msg_cnt, msg_cnt_nxt;
  logic               wr_accept, msg_inc, msg_dec;
  logic               wr_first;
  logic [ADDR_W-1:0]  msg_addr;
  logic               msg_prio;
  tx_entry_t          wr_e, rd_e;
  logic [ENTRY_W-1:0] wr_vec, rd_vec;
  logic               rd_adv, rd_rewind, commit;
  logic               cur_last, cur_last_nxt;
  logic               fail_seen, fail_nxt;
  logic [ADDR_W-1:0]  tx_addr_nxt;
  logic [DATA_W-1:0]  tx_data_nxt;
  logic               tx_pend_nxt, tx_req_nxt, tx_prio_nxt, resp_ack_nxt;
  logic               done_nxt, err_nxt, busy_nxt;
`ifdef ULPB_TX_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0]      retry, retry_nxt;
`endif

  assign wr_accept = WR_EN && !FULL;
  assign msg_inc   = wr_accept && WR_LAST;

  // Address and priority belong to the message, so later words reuse the first word's.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      wr_first <= 1'b1;
    else if (wr_accept)
      wr_first <= WR_LAST;
  end

  always_ff @(posedge CLK) begin
    if (wr_accept && wr_first) begin
      msg_addr <= WR_ADDR;
      msg_prio <= WR_PRIO;
    end
  end

  always_comb begin
    wr_e.prio = wr_first ? WR_PRIO : msg_prio;
    wr_e.addr = wr_first ? WR_ADDR : msg_addr;
    wr_e.last = WR_LAST;
    wr_e.data = WR_DATA;
  end

  assign wr_vec = wr_e;
  assign rd_e   = rd_vec;

  ulpb_tx_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .CLK       (CLK),
    .RESET     (RESET),
    .wr_en     (wr_accept),
    .wr_entry  (wr_vec),
    .rd_adv    (rd_adv),
    .rd_rewind (rd_rewind),
    .commit    (commit),
    .rd_entry  (rd_vec),
    .full      (FULL)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      msg_cnt     <= '0;
      cur_last    <= 1'b0;
      fail_seen   <= 1'b0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_PEND     <= 1'b0;
      TX_REQ      <= 1'b0;
      TX_PRIORITY <= 1'b0;
      TX_RESP_ACK <= 1'b0;
      MSG_DONE    <= 1'b0;
      MSG_ERR     <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_nxt;
      msg_cnt     <= msg_cnt_nxt;
      cur_last    <= cur_last_nxt;
      fail_seen   <= fail_nxt;
      TX_ADDR     <= tx_addr_nxt;
      TX_DATA     <= tx_data_nxt;
      TX_PEND     <= tx_pend_nxt;
      TX_REQ      <= tx_req_nxt;
      TX_PRIORITY <= tx_prio_nxt;
      TX_RESP_ACK <= resp_ack_nxt;
      MSG_DONE    <= done_nxt;
      MSG_ERR     <= err_nxt;
      BUSY        <= busy_nxt;
    end
  end

`ifdef ULPB_TX_RETRY_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      retry <= '0;
    else
      retry <= retry_nxt;
  end
`endif

  always_comb begin
    state_nxt    = state;
    tx_addr_nxt  = TX_ADDR;
    tx_data_nxt  = TX_DATA;
    tx_pend_nxt  = TX_PEND;
    tx_prio_nxt  = TX_PRIORITY;
    tx_req_nxt   = TX_REQ;
    resp_ack_nxt = TX_RESP_ACK;
    cur_last_nxt = cur_last;
    fail_nxt     = fail_seen;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    rd_adv       = 1'b0;
    rd_rewind    = 1'b0;
    commit       = 1'b0;
    msg_dec      = 1'b0;
`ifdef ULPB_TX_RETRY_EN
    retry_nxt    = retry;
`endif
    case (state)
      S_IDLE: begin
        if (msg_cnt != '0)
          state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (TX_FAIL) begin
          tx_req_nxt = 1'b0;
          state_nxt  = S_RESP;
        end else begin
          tx_addr_nxt  = rd_e.addr;
          tx_data_nxt  = rd_e.data;
          tx_prio_nxt  = rd_e.prio;
          tx_pend_nxt  = ~rd_e.last;
          cur_last_nxt = rd_e.last;
          tx_req_nxt   = 1'b1;
          state_nxt    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (TX_FAIL) begin
          tx_req_nxt = 1'b0;
          state_nxt  = S_RESP;
        end else if (TX_ACK) begin
          tx_req_nxt = 1'b0;
          rd_adv     = 1'b1;
          state_nxt  = S_ACK_LOW;
        end
      end
      S_ACK_LOW: begin
        if (TX_FAIL)
          state_nxt = S_RESP;
        else if (!TX_ACK)
          state_nxt = cur_last ? S_RESP : S_LOAD;
      end
      S_RESP: begin
        if (TX_SUCC || TX_FAIL) begin
          resp_ack_nxt = 1'b1;
          fail_nxt     = TX_FAIL;
          state_nxt    = S_RESP_CLR;
        end
      end
      S_RESP_CLR: begin
        // FAIL wins even if it only overlapped SUCC briefly during the clear.
        fail_nxt = fail_seen | TX_FAIL;
        if (!TX_SUCC && !TX_FAIL) begin
          resp_ack_nxt = 1'b0;
          if (fail_seen) begin
            rd_rewind = 1'b1;
`ifdef ULPB_TX_RETRY_EN
            if (retry < RW'(MAX_RETRY)) begin
              retry_nxt = retry + 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_DISCARD;
            end
`else
            state_nxt = S_DISCARD;
`endif
          end else begin
            commit    = 1'b1;
            done_nxt  = 1'b1;
            msg_dec   = 1'b1;
            state_nxt = S_IDLE;
`ifdef ULPB_TX_RETRY_EN
            retry_nxt = '0;
`endif
          end
        end
      end
      S_DISCARD: begin
        rd_adv = 1'b1;
        if (rd_e.last) begin
          commit    = 1'b1;
          err_nxt   = 1'b1;
          msg_dec   = 1'b1;
          state_nxt = S_IDLE;
`ifdef ULPB_TX_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    msg_cnt_nxt = msg_cnt + CW'(msg_inc) - CW'(msg_dec);
    busy_nxt    = (state_nxt != S_IDLE) || (msg_cnt_nxt != '0);
  end

endmodule

// File: tb/tb_ulpb_tx_sequencer.sv
// Scoreboard bench for ulpb_tx_sequencer: directed messages, a scripted node model,
// and a monitor that checks every presented word and every MSG_DONE/MSG_ERR pulse.
module tb_ulpb_tx_sequencer;
  import ulpb_tx_sequencer_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              WR_EN = 1'b0;
  logic [ADDR_W-1:0] WR_ADDR = '0;
  logic [DATA_W-1:0] WR_DATA = '0;
  logic              WR_LAST = 1'b0;
  logic              WR_PRIO = 1'b0;
  logic              FULL, BUSY, MSG_DONE, MSG_ERR;
  logic [ADDR_W-1:0] TX_ADDR;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK;
  logic              TX_ACK = 1'b0;
  logic              TX_SUCC = 1'b0;
  logic              TX_FAIL = 1'b0;

  ulpb_tx_sequencer #(.DEPTH(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_LAST(WR_LAST), .WR_PRIO(WR_PRIO),
    .FULL(FULL), .BUSY(BUSY), .MSG_DONE(MSG_DONE), .MSG_ERR(MSG_ERR),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .TX_PRIORITY(TX_PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              pend;
    logic              prio;
  } wexp_t;

  // fail_word: word index at which the node raises TX_FAIL instead of ACK (-1: none)
  typedef struct {
    int fail_word;
    bit fail;
    int delay;
  } plan_t;

  wexp_t exp_words[$];
  byte   exp_ev[$];
  plan_t plans[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s", name);
  endtask

  // Monitor
  logic  prev_req = 1'b0;
  wexp_t mon_e;
  byte   mon_ev;

  task automatic ev_chk(input byte got);
    if (exp_ev.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL event unexpected actual=%c required=none", got);
    end else begin
      mon_ev = exp_ev.pop_front();
      chk("event", got, mon_ev);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      if (TX_REQ && !prev_req) begin
        if (exp_words.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word unexpected actual=%0h:%0h required=none", TX_ADDR, TX_DATA);
        end else begin
          mon_e = exp_words.pop_front();
          chk("word_addr", TX_ADDR, mon_e.a);
          chk("word_data", TX_DATA, mon_e.d);
          chk("word_pend", TX_PEND, mon_e.pend);
          chk("word_prio", TX_PRIORITY, mon_e.prio);
        end
      end
      if (MSG_DONE) ev_chk("D");
      if (MSG_ERR)  ev_chk("E");
    end
    prev_req = TX_REQ;
  end

  // Node model
  int    node_idx = 0;
  plan_t cur;
  logic  cur_pend;

  task automatic node_wait_resp(input logic val);
    int n = 0;
    while (TX_RESP_ACK !== val && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 500) timeout("node_resp_ack");
  endtask

  task automatic node_wait_req_low();
    int n = 0;
    while (TX_REQ !== 1'b0 && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 500) timeout("node_req_low");
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (RESET && TX_REQ && !TX_ACK) begin
        if (node_idx == 0) begin
          if (plans.size() == 0) begin
            timeout("node_no_plan");
            cur = '{fail_word: -1, fail: 1'b0, delay: 0};
          end else begin
            cur = plans.pop_front();
          end
        end
        cur_pend = TX_PEND;
        if (cur.fail_word == node_idx) begin
          TX_FAIL = 1'b1;
          node_wait_resp(1'b1);
          TX_FAIL = 1'b0;
          node_wait_resp(1'b0);
          node_idx = 0;
        end else begin
          TX_ACK = 1'b1;
          node_wait_req_low();
          TX_ACK = 1'b0;
          node_idx++;
          if (!cur_pend) begin
            repeat (cur.delay) @(posedge CLK);
            #1;
            if (cur.fail) TX_FAIL = 1'b1;
            else          TX_SUCC = 1'b1;
            node_wait_resp(1'b1);
            TX_FAIL = 1'b0;
            TX_SUCC = 1'b0;
            node_wait_resp(1'b0);
            node_idx = 0;
          end
        end
      end
    end
  end

  // Stimulus
  task automatic send_msg(input logic [ADDR_W-1:0] addr, input logic prio, input int n,
                          input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      WR_EN   = 1'b1;
      WR_ADDR = (i == 0) ? addr : ~addr;
      WR_PRIO = (i == 0) ? prio : ~prio;
      WR_DATA = base + DATA_W'(i);
      WR_LAST = (i == n - 1);
      @(posedge CLK); #1;
    end
    WR_EN   = 1'b0;
    WR_LAST = 1'b0;
  endtask

  task automatic push_words(input logic [ADDR_W-1:0] addr, input logic prio, input int n,
                            input logic [DATA_W-1:0] base, input int k);
    for (int i = 0; i < k; i++)
      exp_words.push_back('{a: addr, d: base + DATA_W'(i), pend: (i != n - 1), prio: prio});
  endtask

  task automatic push_plan(input int fail_word, input bit fail, input int delay);
    plans.push_back('{fail_word: fail_word, fail: fail, delay: delay});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_words.size() != 0 || exp_ev.size() != 0 || plans.size() != 0 || BUSY) && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 3000) begin
      timeout(name);
      exp_words.delete();
      exp_ev.delete();
      plans.delete();
    end
    chk({name, "_full"}, FULL, 1'b0);
    chk({name, "_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    logic prev_full;
    int   n;

    repeat (3) @(negedge CLK);
    chk("rst_full", FULL, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_req", TX_REQ, 1'b0);
    chk("rst_pend", TX_PEND, 1'b0);
    chk("rst_addr", TX_ADDR, '0);
    chk("rst_data", TX_DATA, '0);
    chk("rst_prio", TX_PRIORITY, 1'b0);
    chk("rst_resp_ack", TX_RESP_ACK, 1'b0);
    chk("rst_done", MSG_DONE, 1'b0);
    chk("rst_err", MSG_ERR, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("idle_req", TX_REQ, 1'b0);
    chk("idle_busy", BUSY, 1'b0);

    // Single-word message
    push_words(8'h12, 1'b0, 1, 32'hDEADBEEF, 1);
    exp_ev.push_back("D");
    push_plan(-1, 1'b0, 0);
    send_msg(8'h12, 1'b0, 1, 32'hDEADBEEF);
    drain("t1");

    // Three words: TX_PEND 1,1,0; address/priority from the first word
    push_words(8'h34, 1'b1, 3, 32'hA0000001, 3);
    exp_ev.push_back("D");
    push_plan(-1, 1'b0, 0);
    send_msg(8'h34, 1'b1, 3, 32'hA0000001);
    drain("t2");

    // Failure after the last word, then success on replay
`ifdef ULPB_TX_RETRY_EN
    push_words(8'h21, 1'b0, 2, 32'hB0000010, 2);
    push_words(8'h21, 1'b0, 2, 32'hB0000010, 2);
    exp_ev.push_back("D");
    push_plan(-1, 1'b1, 2);
    push_plan(-1, 1'b0, 0);
`else
    push_words(8'h21, 1'b0, 2, 32'hB0000010, 2);
    exp_ev.push_back("E");
    push_plan(-1, 1'b1, 2);
`endif
    send_msg(8'h21, 1'b0, 2, 32'hB0000010);
    drain("t3");

    // Persistent failure drops the message; the queued one follows
`ifdef ULPB_TX_RETRY_EN
    for (int i = 0; i < 4; i++) begin
      push_words(8'h40, 1'b1, 1, 32'hC0000040, 1);
      push_plan(-1, 1'b1, 0);
    end
`else
    push_words(8'h40, 1'b1, 1, 32'hC0000040, 1);
    push_plan(-1, 1'b1, 0);
`endif
    exp_ev.push_back("E");
    push_words(8'h41, 1'b0, 1, 32'hC0000041, 1);
    exp_ev.push_back("D");
    push_plan(-1, 1'b0, 0);
    send_msg(8'h40, 1'b1, 1, 32'hC0000040);
    send_msg(8'h41, 1'b0, 1, 32'hC0000041);
    drain("t4");

    // Failure during word 2 of 4: discard skips words 3-4
`ifdef ULPB_TX_RETRY_EN
    for (int i = 0; i < 4; i++) begin
      push_words(8'h50, 1'b0, 4, 32'hD0000050, 2);
      push_plan(1, 1'b0, 0);
    end
`else
    push_words(8'h50, 1'b0, 4, 32'hD0000050, 2);
    push_plan(1, 1'b0, 0);
`endif
    exp_ev.push_back("E");
    push_words(8'h51, 1'b1, 2, 32'hD0000060, 2);
    exp_ev.push_back("D");
    push_plan(-1, 1'b0, 0);
    send_msg(8'h50, 1'b0, 4, 32'hD0000050);
    send_msg(8'h51, 1'b1, 2, 32'hD0000060);
    drain("t5");

    // Fill all 16 entries while the first message awaits its response
    push_words(8'h56, 1'b0, 1, 32'hE0000000, 1);
    push_plan(-1, 1'b0, 40);
    exp_ev.push_back("D");
    push_words(8'h78, 1'b1, 15, 32'hE0000100, 15);
    push_plan(-1, 1'b0, 0);
    exp_ev.push_back("D");
    send_msg(8'h56, 1'b0, 1, 32'hE0000000);
    send_msg(8'h78, 1'b1, 15, 32'hE0000100);
    chk("t6_full_16", FULL, 1'b1);
    send_msg(8'h99, 1'b0, 1, 32'h0BAD0BAD);
    chk("t6_full_17", FULL, 1'b1);
    n = 0;
    prev_full = FULL;
    while (MSG_DONE !== 1'b1 && n < 500) begin
      prev_full = FULL;
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 500) begin
      timeout("t6_done");
    end else begin
      chk("t6_full_before_commit", prev_full, 1'b1);
      chk("t6_full_after_commit", FULL, 1'b0);
    end
    drain("t6");

    repeat (5) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule
